// File: rtl/polaris_uart_pkg.sv
// Shared types and constants for the Polaris UART receive path.
package polaris_uart_pkg;

  localparam int UART_DIV_W   = 12;
  localparam int UART_DIV_MIN = 4;
  localparam int UART_DATA_W  = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/polaris_uart_rx_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; pop on empty is ignored,
// push on full only lands when a pop frees the slot in the same cycle.
module polaris_uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer bookkeeping; extra MSB distinguishes full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/polaris_uart_rx.sv
// Polaris UART receiver: pin synchroniser, 8N1 deserialiser FSM, RX byte FIFO
// and sticky overrun flag.
module polaris_uart_rx
  import polaris_uart_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int SYNC_FF  = 2
) (
  input  logic                        uart_clock_i,
  input  logic                        uart_reset_i,
  input  logic                        rx_en_i,
  input  logic [UART_DIV_W-1:0]       clk_div_i,
  input  logic                        uart_rx_i,
  input  logic                        rx_read_i,
  output logic [UART_DATA_W-1:0]      rx_data_o,
  output logic                        rx_empty_o,
  output logic                        rx_full_o,
  output logic [$clog2(RX_DEPTH):0]   rx_count_o,
  output logic                        rx_busy_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  input  logic                        overrun_clr_i
);

  logic [SYNC_FF-1:0]     sync_q;
  logic                   rxs;
  logic                   rxs_q;
  rx_state_e              state_q;
  logic [UART_DIV_W-1:0]  div_q;
  logic [UART_DIV_W-1:0]  cnt_q;
  logic [2:0]             idx_q;
  logic [UART_DATA_W-1:0] sr_q;
  logic                   ferr_q;
  logic                   ovr_q;
  logic                   active;
  logic                   push;
  logic                   ovr_set;

  assign rxs     = sync_q[SYNC_FF-1];
  assign active  = rx_en_i && (clk_div_i >= UART_DIV_W'(UART_DIV_MIN));
  // Stop bit sampled high: the assembled byte goes straight into the FIFO.
  assign push    = active && (state_q == RX_STOP) && (cnt_q == '0) && rxs;
  assign ovr_set = push && rx_full_o && !rx_read_i;

  assign rx_busy_o   = (state_q != RX_IDLE);
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

  // Pin synchroniser plus one extra delayed copy for falling-edge detection.
  always_ff @(posedge uart_clock_i or posedge uart_reset_i) begin
    if (uart_reset_i) begin
      sync_q <= '1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_FF-2:0], uart_rx_i};
      rxs_q  <= rxs;
    end
  end

  // Frame FSM: mid-bit sampling driven by a per-frame latched divider.
  always_ff @(posedge uart_clock_i or posedge uart_reset_i) begin
    if (uart_reset_i) begin
      state_q <= RX_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      if (!active) begin
        state_q <= RX_IDLE;
      end else begin
        case (state_q)
          RX_IDLE: begin
            if (rxs_q && !rxs) begin
              state_q <= RX_START;
              div_q   <= clk_div_i;
              cnt_q   <= (clk_div_i >> 1) - 1'b1;
            end
          end
          RX_START: begin
            if (cnt_q == '0) begin
              if (rxs) begin
                state_q <= RX_IDLE;
              end else begin
                state_q <= RX_DATA;
                cnt_q   <= div_q - 1'b1;
                idx_q   <= '0;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          RX_DATA: begin
            if (cnt_q == '0) begin
              sr_q  <= {rxs, sr_q[UART_DATA_W-1:1]};
              cnt_q <= div_q - 1'b1;
              if (idx_q == 3'd7) state_q <= RX_STOP;
              else               idx_q   <= idx_q + 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          RX_STOP: begin
            // Return to IDLE mid-stop-bit so a back-to-back start edge is seen.
            if (cnt_q == '0) begin
              state_q <= RX_IDLE;
              ferr_q  <= !rxs;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  // Sticky overrun: a set in the same cycle as a clear wins.
  always_ff @(posedge uart_clock_i or posedge uart_reset_i) begin
    if (uart_reset_i)       ovr_q <= 1'b0;
    else if (ovr_set)       ovr_q <= 1'b1;
    else if (overrun_clr_i) ovr_q <= 1'b0;
  end

  polaris_uart_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk_i       (uart_clock_i),
    .rst_i       (uart_reset_i),
    .push_i      (push),
    .push_data_i (sr_q),
    .pop_i       (rx_read_i),
    .head_o      (rx_data_o),
    .count_o     (rx_count_o),
    .full_o      (rx_full_o),
    .empty_o     (rx_empty_o)
  );

endmodule

// File: tb/tb_polaris_uart_rx.sv
// Bench for polaris_uart_rx: directed frame table, timing corner cases and
// randomized frames checked against a queue-based FIFO model.
module tb_polaris_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_en = 1'b1;
  logic [11:0] clk_div = 12'd16;
  logic        rx_pin = 1'b1;
  logic        rx_read = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_empty, rx_full, rx_busy, ferr, ovr;
  logic [4:0]  rx_count;

  int nvec = 0;
  int nmis = 0;
  int ferr_seen = 0;

  polaris_uart_rx #(.RX_DEPTH(16), .SYNC_FF(2)) dut (
    .uart_clock_i  (clk),
    .uart_reset_i  (rst),
    .rx_en_i       (rx_en),
    .clk_div_i     (clk_div),
    .uart_rx_i     (rx_pin),
    .rx_read_i     (rx_read),
    .rx_data_o     (rx_data),
    .rx_empty_o    (rx_empty),
    .rx_full_o     (rx_full),
    .rx_count_o    (rx_count),
    .rx_busy_o     (rx_busy),
    .frame_err_o   (ferr),
    .overrun_o     (ovr),
    .overrun_clr_i (ovr_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ferr === 1'b1) ferr_seen++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop();
    rx_read = 1'b1;
    tick();
    rx_read = 1'b0;
  endtask

  // Drive one 8N1 frame, d cycles per bit, starting in the current cycle.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int d);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_pin = f[i];
      repeat (d) tick();
    end
    rx_pin = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         reads;
    bit         exp_empty;
    int         exp_count;
    logic [7:0] exp_head;
    int         exp_ferr;
  } vec_t;

  vec_t vt [6];

  logic [7:0] mq [$];
  bit         m_ovr;
  int         m_ferr;

  initial begin
    int d;
    int s_off;
    int f0;
    logic [7:0] b;
    bit st;

    vt[0] = '{8'h5A, 1'b1, 0, 1'b0, 1, 8'h5A, 0};
    vt[1] = '{8'hFF, 1'b1, 0, 1'b0, 2, 8'h5A, 0};
    vt[2] = '{8'h00, 1'b0, 0, 1'b0, 2, 8'h5A, 1};
    vt[3] = '{8'h81, 1'b1, 1, 1'b0, 2, 8'hFF, 0};
    vt[4] = '{8'h7E, 1'b0, 2, 1'b1, 0, 8'h00, 1};
    vt[5] = '{8'hC3, 1'b1, 0, 1'b0, 1, 8'hC3, 0};

    // Reset values
    repeat (3) tick();
    chk("rst_empty", rx_empty, 1);
    chk("rst_full", rx_full, 0);
    chk("rst_count", rx_count, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    rst = 1'b0;
    repeat (5) tick();

    // 0xA5: exact push timing; stop sample cycle is 2+d/2+9d after frame start
    d = 16;
    s_off = 2 + d / 2 + 9 * d;
    fork
      send(8'hA5, 1'b1, d);
      begin
        repeat (s_off) tick();
        chk("a5_empty_at_sample", rx_empty, 1);
        chk("a5_busy_at_sample", rx_busy, 1);
        tick();
        chk("a5_empty_after", rx_empty, 0);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_ferr", ferr, 0);
        chk("a5_busy_after", rx_busy, 0);
      end
    join
    repeat (3) tick();
    pop();
    chk("a5_pop_empty", rx_empty, 1);

    // Start glitch shorter than half a bit
    rx_pin = 1'b0;
    repeat (4) tick();
    rx_pin = 1'b1;
    repeat (40) tick();
    chk("glitch_busy", rx_busy, 0);
    chk("glitch_empty", rx_empty, 1);

    // 0x3C with bad stop bit
    f0 = ferr_seen;
    fork
      send(8'h3C, 1'b0, d);
      begin
        repeat (s_off + 1) tick();
        chk("ferr_pulse_hi", ferr, 1);
        tick();
        chk("ferr_pulse_lo", ferr, 0);
      end
    join
    repeat (3) tick();
    chk("ferr_count", rx_count, 0);
    chk("ferr_single", ferr_seen - f0, 1);

    // Directed frame table
    foreach (vt[i]) begin
      repeat (vt[i].reads) pop();
      f0 = ferr_seen;
      send(vt[i].data, vt[i].stop_ok, d);
      repeat (4) tick();
      chk($sformatf("tbl%0d_count", i), rx_count, vt[i].exp_count);
      chk($sformatf("tbl%0d_empty", i), rx_empty, vt[i].exp_empty);
      chk($sformatf("tbl%0d_ferr", i), ferr_seen - f0, vt[i].exp_ferr);
      if (!vt[i].exp_empty) chk($sformatf("tbl%0d_head", i), rx_data, vt[i].exp_head);
    end
    pop();
    chk("tbl_drained", rx_empty, 1);

    // Randomized frames against the queue model
    mq.delete();
    m_ovr = 1'b0;
    m_ferr = 0;
    f0 = ferr_seen;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 2)) begin
        pop();
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        m_ovr = 1'b0;
      end
      d = $urandom_range(8, 24);
      clk_div = 12'(d);
      repeat (3) tick();
      b = 8'($urandom);
      st = ($urandom_range(0, 7) != 0);
      send(b, st, d);
      // Divider change after the frame must not matter to it
      clk_div = 12'($urandom_range(4, 40));
      repeat (3) tick();
      if (!st) m_ferr++;
      else if (mq.size() < 16) mq.push_back(b);
      else m_ovr = 1'b1;
      chk($sformatf("rnd%0d_count", n), rx_count, mq.size());
      chk($sformatf("rnd%0d_full", n), rx_full, (mq.size() == 16));
      chk($sformatf("rnd%0d_ovr", n), ovr, m_ovr);
      chk($sformatf("rnd%0d_ferr", n), ferr_seen - f0, m_ferr);
      if (mq.size() > 0) chk($sformatf("rnd%0d_head", n), rx_data, mq[0]);
    end

    // Drain, clear overrun, then fill to overflow
    repeat (16) pop();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("drain_empty", rx_empty, 1);
    chk("drain_ovr", ovr, 0);
    d = 16;
    clk_div = 12'd16;
    repeat (3) tick();
    for (int i = 0; i <= 16; i++) send(8'(i), 1'b1, d);
    repeat (3) tick();
    chk("ovf_count", rx_count, 16);
    chk("ovf_full", rx_full, 1);
    chk("ovf_ovr", ovr, 1);
    chk("ovf_head", rx_data, 8'h00);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovf_clr", ovr, 0);

    // Full FIFO, pop on the push cycle of 0x55
    fork
      send(8'h55, 1'b1, d);
      begin
        repeat (s_off) tick();
        rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
        chk("pp_count", rx_count, 16);
        chk("pp_ovr", ovr, 0);
        chk("pp_full", rx_full, 1);
        chk("pp_head", rx_data, 8'h01);
      end
    join
    repeat (15) pop();
    chk("pp_last", rx_data, 8'h55);
    chk("pp_last_count", rx_count, 1);
    pop();

    // Back-to-back frames with no idle gap
    send(8'h12, 1'b1, d);
    send(8'h34, 1'b1, d);
    repeat (3) tick();
    chk("b2b_count", rx_count, 2);
    chk("b2b_first", rx_data, 8'h12);
    pop();
    chk("b2b_second", rx_data, 8'h34);

    // Reset during data bit 3 of 0x99
    b = 8'h99;
    rx_pin = 1'b0;
    repeat (d) tick();
    for (int i = 0; i < 3; i++) begin
      rx_pin = b[i];
      repeat (d) tick();
    end
    rx_pin = b[3];
    repeat (d / 2) tick();
    chk("mid_busy", rx_busy, 1);
    rst = 1'b1;
    rx_pin = 1'b1;
    #1;
    chk("mid_rst_empty", rx_empty, 1);
    chk("mid_rst_count", rx_count, 0);
    chk("mid_rst_busy", rx_busy, 0);
    chk("mid_rst_full", rx_full, 0);
    chk("mid_rst_ferr", ferr, 0);
    chk("mid_rst_ovr", ovr, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3 * d) tick();
    send(8'h81, 1'b1, d);
    repeat (3) tick();
    chk("post_rst_count", rx_count, 1);
    chk("post_rst_data", rx_data, 8'h81);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
